wb_cfg_master: RTL and testbench

WB_CFG_MASTER -- requirements
Module: wb_cfg_master

---
 rtl/wb_cfg_master.sv | 113 +++++++++++
 tb/tb_wb_cfg_master.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cfg_master.sv
// Wishbone classic single-transfer initiator (IDLE -> BUS -> RESP) with an ack timeout.
// stb rises 1 cycle after cmd accept, rsp_valid 1 cycle after ack; cmd_ready stays low until the response is consumed.
module wb_cfg_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbs_cyc_o,
  output logic        wbs_stb_o,
  output logic        wbs_we_o,
  output logic [31:0] wbs_adr_o,
  output logic [31:0] wbs_dat_o,
  output logic [3:0]  wbs_sel_o,
  input  logic        wbs_ack_i,
  input  logic [31:0] wbs_dat_i,
  output logic        busy
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t        state;
  logic [CW-1:0] tmo_cnt;
  logic          rdy_q;

  // The register comes out of reset high so cmd_ready is valid on the first
  // cycle after release; gating with reset keeps it low while reset is held.
  assign cmd_ready = rdy_q & ~wb_rst_i;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      rdy_q     <= 1'b1;
      busy      <= 1'b0;
      wbs_cyc_o <= 1'b0;
      wbs_stb_o <= 1'b0;
      wbs_we_o  <= 1'b0;
      wbs_adr_o <= '0;
      wbs_dat_o <= '0;
      wbs_sel_o <= '0;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            wbs_we_o  <= cmd_we;
            wbs_adr_o <= cmd_adr;
            wbs_dat_o <= cmd_dat;
            wbs_sel_o <= cmd_sel;
            wbs_cyc_o <= 1'b1;
            wbs_stb_o <= 1'b1;
            tmo_cnt   <= '0;
            rdy_q     <= 1'b0;
            busy      <= 1'b1;
            state     <= BUS;
          end
        end
        BUS: begin
          // Ack is checked first so a reply arriving on the timeout cycle wins.
          if (wbs_ack_i) begin
            wbs_cyc_o <= 1'b0;
            wbs_stb_o <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_dat   <= wbs_we_o ? 32'h0 : wbs_dat_i;
            state     <= RESP;
          end else if (tmo_cnt == TMO) begin
            wbs_cyc_o <= 1'b0;
            wbs_stb_o <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_dat   <= 32'h0;
            state     <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rdy_q     <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          rdy_q     <= 1'b1;
          busy      <= 1'b0;
          wbs_cyc_o <= 1'b0;
          wbs_stb_o <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cfg_master.sv
// Directed bench for wb_cfg_master: vector table plus hand-written backpressure, reset and stray-ack sequences.
// dut_a uses TIMEOUT_CYCLES=4, dut_b the default 255 for long waited reads.
module tb_wb_cfg_master;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        cmd_valid, cmd_we, rsp_ready, ack, use_b;
  logic [31:0] cmd_adr, cmd_dat, dat_i;
  logic [3:0]  cmd_sel;

  logic        cmd_ready_a, rsp_valid_a, rsp_err_a, cyc_a, stb_a, we_a, busy_a;
  logic [31:0] rsp_dat_a, adr_a, dat_o_a;
  logic [3:0]  sel_a;
  logic        cmd_ready_b, rsp_valid_b, rsp_err_b, cyc_b, stb_b, we_b, busy_b;
  logic [31:0] rsp_dat_b, adr_b, dat_o_b;
  logic [3:0]  sel_b;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_cfg_master #(.TIMEOUT_CYCLES(4)) dut_a (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .cmd_valid(cmd_valid & ~use_b), .cmd_ready(cmd_ready_a),
    .cmd_we(cmd_we), .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready & ~use_b),
    .rsp_dat(rsp_dat_a), .rsp_err(rsp_err_a),
    .wbs_cyc_o(cyc_a), .wbs_stb_o(stb_a), .wbs_we_o(we_a),
    .wbs_adr_o(adr_a), .wbs_dat_o(dat_o_a), .wbs_sel_o(sel_a),
    .wbs_ack_i(ack), .wbs_dat_i(dat_i), .busy(busy_a)
  );

  wb_cfg_master dut_b (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .cmd_valid(cmd_valid & use_b), .cmd_ready(cmd_ready_b),
    .cmd_we(cmd_we), .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready & use_b),
    .rsp_dat(rsp_dat_b), .rsp_err(rsp_err_b),
    .wbs_cyc_o(cyc_b), .wbs_stb_o(stb_b), .wbs_we_o(we_b),
    .wbs_adr_o(adr_b), .wbs_dat_o(dat_o_b), .wbs_sel_o(sel_b),
    .wbs_ack_i(ack), .wbs_dat_i(dat_i), .busy(busy_b)
  );

  logic        m_cmd_ready, m_rsp_valid, m_rsp_err, m_cyc, m_stb, m_we, m_busy;
  logic [31:0] m_rsp_dat, m_adr, m_dat_o;
  logic [3:0]  m_sel;

  assign m_cmd_ready = use_b ? cmd_ready_b : cmd_ready_a;
  assign m_rsp_valid = use_b ? rsp_valid_b : rsp_valid_a;
  assign m_rsp_err   = use_b ? rsp_err_b   : rsp_err_a;
  assign m_rsp_dat   = use_b ? rsp_dat_b   : rsp_dat_a;
  assign m_cyc       = use_b ? cyc_b       : cyc_a;
  assign m_stb       = use_b ? stb_b       : stb_a;
  assign m_we        = use_b ? we_b        : we_a;
  assign m_adr       = use_b ? adr_b       : adr_a;
  assign m_dat_o     = use_b ? dat_o_b     : dat_o_a;
  assign m_sel       = use_b ? sel_b       : sel_a;
  assign m_busy      = use_b ? busy_b      : busy_a;

  typedef struct {
    logic        b;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          ack_at;   // stb cycle index that gets ack, -1 = never
    logic [31:0] rdat;
    int          exp_stb;
    logic [31:0] exp_dat;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   nstb;
    logic fld_ok;
    use_b = v.b;
    chk($sformatf("v%0d_cmd_ready", idx), {31'b0, m_cmd_ready}, 32'd1);
    cmd_we = v.we; cmd_adr = v.adr; cmd_dat = v.dat; cmd_sel = v.sel;
    cmd_valid = 1'b1;
    @(negedge wb_clk_i);
    cmd_valid = 1'b0;
    cmd_adr = 32'hFFFF_FFFF; cmd_dat = 32'h5555_5555; cmd_sel = 4'h0; cmd_we = ~v.we;
    nstb = 0;
    fld_ok = 1'b1;
    for (int k = 0; k < 300 && m_stb; k++) begin
      nstb++;
      if (!m_cyc || m_adr !== v.adr || m_we !== v.we || m_dat_o !== v.dat || m_sel !== v.sel)
        fld_ok = 1'b0;
      ack   = (k == v.ack_at);
      dat_i = (k == v.ack_at) ? v.rdat : 32'hBAD0_BAD0;
      @(negedge wb_clk_i);
    end
    ack = 1'b0;
    chk($sformatf("v%0d_stb_cycles", idx), nstb, v.exp_stb);
    chk($sformatf("v%0d_bus_fields", idx), {31'b0, fld_ok}, 32'd1);
    chk($sformatf("v%0d_rsp_valid", idx), {31'b0, m_rsp_valid}, 32'd1);
    chk($sformatf("v%0d_rsp_dat", idx), m_rsp_dat, v.exp_dat);
    chk($sformatf("v%0d_rsp_err", idx), {31'b0, m_rsp_err}, {31'b0, v.exp_err});
    chk($sformatf("v%0d_cyc_low", idx), {31'b0, m_cyc}, 32'd0);
    chk($sformatf("v%0d_busy_resp", idx), {31'b0, m_busy}, 32'd1);
    rsp_ready = 1'b1;
    @(negedge wb_clk_i);
    rsp_ready = 1'b0;
    chk($sformatf("v%0d_rsp_done", idx), {31'b0, m_rsp_valid}, 32'd0);
    chk($sformatf("v%0d_idle_ready", idx), {31'b0, m_cmd_ready}, 32'd1);
    chk($sformatf("v%0d_dat_o_kept", idx), m_dat_o, v.dat);
  endtask

  initial begin
    logic bp_ok, rv_seen, idle_ok;
    wb_rst_i = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
    cmd_sel = '0; rsp_ready = 1'b0; ack = 1'b0; dat_i = '0; use_b = 1'b0;

    //          b     we    adr            dat            sel   ack  rdat           stb exp_dat        err
    vecs[0] = '{1'b0, 1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF,  0, 32'hFFFF_FFFF, 1, 32'h0,         1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'h3000_0000, 32'h0000_0000, 4'hF,  5, 32'h1234_5678, 6, 32'h1234_5678, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 32'h3000_0008, 32'h0000_0011, 4'h3, -1, 32'h0,         5, 32'h0,         1'b1};
    vecs[3] = '{1'b0, 1'b0, 32'h3000_000C, 32'h0000_0022, 4'hF,  0, 32'hA5A5_0001, 1, 32'hA5A5_0001, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 32'h3000_0010, 32'h0000_0033, 4'hC,  4, 32'hCAFE_F00D, 5, 32'hCAFE_F00D, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 32'h3000_0014, 32'h0BB0_0CC0, 4'h1,  2, 32'h7777_7777, 3, 32'h0,         1'b0};
    vecs[6] = '{1'b1, 1'b0, 32'h3000_0018, 32'h0000_0044, 4'hF,  0, 32'h600D_CAFE, 1, 32'h600D_CAFE, 1'b0};

    repeat (2) @(negedge wb_clk_i);
    chk("rst_cmd_ready", {31'b0, cmd_ready_a}, 32'd0);
    chk("rst_cyc",       {31'b0, cyc_a | stb_a | we_a}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid_a}, 32'd0);
    chk("rst_busy",      {31'b0, busy_a}, 32'd0);
    chk("rst_adr",       adr_a | dat_o_a | rsp_dat_a, 32'd0);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    chk("rel_cmd_ready", {31'b0, cmd_ready_a & cmd_ready_b}, 32'd1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Response backpressure with the next command already waiting.
    use_b = 1'b0;
    cmd_we = 1'b0; cmd_adr = 32'h3000_0020; cmd_sel = 4'hF; cmd_valid = 1'b1;
    @(negedge wb_clk_i);
    cmd_we = 1'b1; cmd_adr = 32'h3000_0024; cmd_dat = 32'h1111_2222; cmd_sel = 4'h5;
    ack = 1'b1; dat_i = 32'h0BAD_F00D;
    @(negedge wb_clk_i);
    ack = 1'b0;
    chk("bp_rsp_valid", {31'b0, m_rsp_valid}, 32'd1);
    chk("bp_rsp_dat", m_rsp_dat, 32'h0BAD_F00D);
    bp_ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      ack = k[0];
      dat_i = $urandom;
      @(negedge wb_clk_i);
      if (!m_rsp_valid || m_rsp_dat !== 32'h0BAD_F00D || m_cmd_ready || m_cyc || m_rsp_err)
        bp_ok = 1'b0;
    end
    ack = 1'b0;
    chk("bp_hold", {31'b0, bp_ok}, 32'd1);
    rsp_ready = 1'b1;
    @(negedge wb_clk_i);
    rsp_ready = 1'b0;
    chk("bp_rsp_done", {31'b0, m_rsp_valid}, 32'd0);
    chk("bp_ready_back", {31'b0, m_cmd_ready}, 32'd1);
    @(negedge wb_clk_i);
    cmd_valid = 1'b0;
    chk("bp_second_stb", {31'b0, m_stb}, 32'd1);
    chk("bp_second_adr", m_adr, 32'h3000_0024);
    chk("bp_second_we", {31'b0, m_we}, 32'd1);
    ack = 1'b1;
    @(negedge wb_clk_i);
    ack = 1'b0;
    chk("bp_second_rsp", {31'b0, m_rsp_valid}, 32'd1);
    chk("bp_second_dat", m_rsp_dat, 32'h0);
    rsp_ready = 1'b1;
    @(negedge wb_clk_i);
    rsp_ready = 1'b0;

    // Reset in the middle of a waited transfer.
    cmd_we = 1'b0; cmd_adr = 32'h3000_0030; cmd_valid = 1'b1;
    @(negedge wb_clk_i);
    cmd_valid = 1'b0;
    @(negedge wb_clk_i);
    chk("mid_stb_before", {31'b0, m_stb}, 32'd1);
    wb_rst_i = 1'b1;
    #1;
    chk("mid_rst_cyc", {31'b0, m_cyc | m_stb}, 32'd0);
    chk("mid_rst_ready", {31'b0, m_cmd_ready}, 32'd0);
    chk("mid_rst_busy", {31'b0, m_busy}, 32'd0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    rv_seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge wb_clk_i);
      if (m_rsp_valid || m_cyc) rv_seen = 1'b1;
    end
    chk("mid_no_rsp", {31'b0, rv_seen}, 32'd0);
    chk("mid_ready_after", {31'b0, m_cmd_ready}, 32'd1);
    chk("mid_adr_cleared", m_adr, 32'h0);

    // Stray acks while idle must be ignored.
    idle_ok = 1'b1;
    ack = 1'b1; dat_i = 32'hFACE_FACE;
    for (int k = 0; k < 3; k++) begin
      @(negedge wb_clk_i);
      if (m_rsp_valid || m_busy || m_cyc || !m_cmd_ready) idle_ok = 1'b0;
    end
    ack = 1'b0;
    chk("stray_ack_idle", {31'b0, idle_ok}, 32'd1);
    run_vec(vecs[4], 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation did not finish");
  end

endmodule
